// File: rtl/tone_gen_multi.sv
// Multi-channel square-wave generator with a shared timebase tick.
// Divisor writes are double-buffered and land on half-period boundaries.
module tone_gen_multi #(
    parameter int CH       = 4,
    parameter int DW       = 11,
    parameter int TICK_DIV = 50000,
    parameter int CW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [DW-1:0] wr_div,
    output logic [CH-1:0] pend,
    output logic [CH-1:0] tone,
    output logic          tick_1khz
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'(TICK_DIV - 1);

    logic [DW-1:0] cnt_q     [CH];
    logic [DW-1:0] div_cur_q [CH];
    logic [DW-1:0] div_nxt_q [CH];
    logic [DW-1:0] cnt_d     [CH];
    logic [DW-1:0] div_cur_d [CH];
    logic [DW-1:0] div_nxt_d [CH];
    logic [CH-1:0] pend_d;
    logic [CH-1:0] tone_d;
    logic [CH-1:0] wr_hit;
    logic [CH-1:0] bnd;

    logic [TW-1:0] tc;

    // decode the write strobe; selects >= CH match nothing
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            wr_hit[i] = wr_en && (wr_ch == CW'(i));
        end
    end

    // half-period boundary: running channel at its last count
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            bnd[i] = (div_cur_q[i] != '0) &&
                     (cnt_q[i] == div_cur_q[i] - DW'(1));
        end
    end

    // per-channel next state from pre-edge register values
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_cur_d[i] = div_cur_q[i];
            div_nxt_d[i] = div_nxt_q[i];
            pend_d[i]    = pend[i];
            tone_d[i]    = tone[i];

            if (sync) begin
                cnt_d[i]  = '0;
                tone_d[i] = 1'b0;
                if (pend[i]) begin
                    div_cur_d[i] = div_nxt_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else if (div_cur_q[i] == '0) begin
                cnt_d[i]  = '0;
                tone_d[i] = 1'b0;
                if (pend[i]) begin
                    div_cur_d[i] = div_nxt_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else if (bnd[i]) begin
                cnt_d[i] = '0;
                if (pend[i]) begin
                    div_cur_d[i] = div_nxt_q[i];
                    pend_d[i]    = 1'b0;
                    if (div_nxt_q[i] == '0) begin
                        tone_d[i] = 1'b0;
                    end else begin
                        tone_d[i] = ~tone[i];
                    end
                end else begin
                    tone_d[i] = ~tone[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + DW'(1);
            end

            // a write always lands in the buffer, even at a boundary
            if (wr_hit[i]) begin
                div_nxt_d[i] = wr_div;
                pend_d[i]    = 1'b1;
            end
        end
    end

    // channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i]     <= '0;
                div_cur_q[i] <= '0;
                div_nxt_q[i] <= '0;
            end
            pend <= '0;
            tone <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_cur_q[i] <= div_cur_d[i];
                div_nxt_q[i] <= div_nxt_d[i];
            end
            pend <= pend_d;
            tone <= tone_d;
        end
    end

    // free-running timebase with a registered one-cycle tick
    always_ff @(posedge clk) begin
        if (rst) begin
            tc        <= '0;
            tick_1khz <= 1'b0;
        end else begin
            tick_1khz <= (tc == TC_LAST);
            if (tc == TC_LAST) begin
                tc <= '0;
            end else begin
                tc <= tc + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tone_gen_multi.sv
// Directed bench for tone_gen_multi with a cycle-indexed
// expectation queue checked on the falling edge.
module tb_tone_gen_multi;

    localparam int CH = 3;
    localparam int DW = 6;
    localparam int TD = 7;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync = 1'b0;
    logic          wr_en = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [DW-1:0] wr_div = '0;
    logic [CH-1:0] pend;
    logic [CH-1:0] tone;
    logic          tick_1khz;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int last = 0;

    typedef struct {
        int    cyc;
        int    kind;
        int    ch;
        bit    val;
        string tag;
    } exp_t;

    exp_t q[$];

    tone_gen_multi #(
        .CH(CH),
        .DW(DW),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sync(sync),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_div(wr_div),
        .pend(pend),
        .tone(tone),
        .tick_1khz(tick_1khz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic obs(input int kind, input int ch);
        case (kind)
            0:       return tone[ch];
            1:       return pend[ch];
            default: return tick_1khz;
        endcase
    endfunction

    always @(negedge clk) begin
        int   i;
        logic o;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                o = obs(q[i].kind, q[i].ch);
                total++;
                assert (o === q[i].val) else begin
                    bad++;
                    $error("FAIL %s ch=%0d cyc=%0d observed=%b expected=%b",
                           q[i].tag, q[i].ch, cyc, o, q[i].val);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic ex(input int kind, input int ch, input int c0,
                      input int c1, input bit v, input string tag);
        for (int c = c0; c <= c1; c++) begin
            q.push_back('{cyc: c, kind: kind, ch: ch, val: v, tag: tag});
            if (c > last) last = c;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_edge(input int e);
        while (cyc < e - 1) step(1);
    endtask

    task automatic wr(input int ch, input int d, output int t);
        wr_en  = 1'b1;
        wr_ch  = CW'(ch);
        wr_div = DW'(d);
        t = cyc + 1;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_sync(output int s);
        sync = 1'b1;
        s = cyc + 1;
        step(1);
        sync = 1'b0;
    endtask

    task automatic do_reset(input bit idle_chk);
        rst    = 1'b1;
        wr_en  = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 6'd5;
        for (int ch = 0; ch < CH; ch++) begin
            ex(0, ch, cyc + 1, cyc + 3, 1'b0, "rst_tone");
            ex(1, ch, cyc + 1, cyc + 3, 1'b0, "rst_pend");
        end
        ex(2, 0, cyc + 1, cyc + 3, 1'b0, "rst_tick");
        step(3);
        rst   = 1'b0;
        wr_en = 1'b0;
        if (idle_chk) begin
            for (int ch = 0; ch < CH; ch++) begin
                ex(0, ch, cyc + 1, cyc + 4, 1'b0, "idle_tone");
                ex(1, ch, cyc + 1, cyc + 4, 1'b0, "idle_pend");
            end
            ex(2, 0, cyc + 1, cyc + 4, 1'b0, "idle_tick");
            step(4);
        end
    endtask

    initial begin
        int t;
        int r;
        int s;

        do_reset(1'b1);

        // start from idle, div 5
        wr(0, 5, t);
        ex(1, 0, t, t, 1'b1, "s1_pend_set");
        ex(1, 0, t + 1, t + 1, 1'b0, "s1_pend_clr");
        ex(0, 0, t, t + 5, 1'b0, "s1_lo");
        ex(0, 0, t + 6, t + 10, 1'b1, "s1_hi");
        ex(0, 0, t + 11, t + 15, 1'b0, "s1_lo2");
        ex(0, 0, t + 16, t + 16, 1'b1, "s1_hi2");
        to_edge(t + 17);

        // glitch-free change 8 -> 3
        do_reset(1'b0);
        wr(1, 8, t);
        ex(0, 1, t, t + 8, 1'b0, "gf_lo");
        ex(0, 1, t + 9, t + 16, 1'b1, "gf_hi8");
        ex(0, 1, t + 17, t + 19, 1'b0, "gf_lo3");
        ex(0, 1, t + 20, t + 22, 1'b1, "gf_hi3");
        ex(0, 1, t + 23, t + 25, 1'b0, "gf_lo3b");
        ex(0, 1, t + 26, t + 26, 1'b1, "gf_hi3b");
        to_edge(t + 12);
        wr(1, 3, r);
        ex(1, 1, t + 12, t + 16, 1'b1, "gf_pend");
        ex(1, 1, t + 17, t + 17, 1'b0, "gf_pend_clr");
        to_edge(t + 27);

        // writes colliding with boundaries
        do_reset(1'b0);
        wr(2, 4, t);
        ex(1, 2, t, t, 1'b1, "col_pend0");
        ex(1, 2, t + 1, t + 8, 1'b0, "col_pend0_clr");
        ex(0, 2, t, t + 4, 1'b0, "col_lo");
        ex(0, 2, t + 5, t + 8, 1'b1, "col_hi4");
        ex(0, 2, t + 9, t + 12, 1'b0, "col_lo4");
        ex(0, 2, t + 13, t + 14, 1'b1, "col_hi2");
        ex(0, 2, t + 15, t + 16, 1'b0, "col_lo2");
        ex(0, 2, t + 17, t + 18, 1'b1, "col_hi2b");
        ex(0, 2, t + 19, t + 23, 1'b0, "col_lo5");
        ex(0, 2, t + 24, t + 26, 1'b1, "col_hi3");
        ex(0, 2, t + 27, t + 29, 1'b0, "col_lo3");
        ex(0, 2, t + 30, t + 30, 1'b1, "col_hi3b");
        ex(1, 2, t + 9, t + 12, 1'b1, "col_pend");
        ex(1, 2, t + 13, t + 13, 1'b0, "col_pend_clr");
        ex(1, 2, t + 18, t + 23, 1'b1, "col_pend_keep");
        ex(1, 2, t + 24, t + 24, 1'b0, "col_pend_clr2");
        to_edge(t + 9);
        wr(2, 2, r);
        to_edge(t + 18);
        wr(2, 5, r);
        wr(2, 3, r);
        to_edge(t + 31);

        // overwrite, invalid channel, mute
        do_reset(1'b0);
        wr(0, 5, t);
        ex(0, 0, t, t + 5, 1'b0, "ow_lo");
        ex(0, 0, t + 6, t + 10, 1'b1, "ow_hi5");
        ex(0, 0, t + 11, t + 16, 1'b0, "ow_lo6");
        ex(0, 0, t + 17, t + 22, 1'b1, "ow_hi6");
        ex(0, 0, t + 23, t + 40, 1'b0, "mute_lo");
        ex(1, 0, t + 7, t + 10, 1'b1, "ow_pend");
        ex(1, 0, t + 11, t + 24, 1'b0, "ow_pend_clr");
        ex(1, 0, t + 25, t + 28, 1'b1, "mute_pend");
        ex(1, 0, t + 29, t + 40, 1'b0, "mute_pend_clr");
        for (int ch = 1; ch < CH; ch++) begin
            ex(0, ch, t, t + 40, 1'b0, "inv_tone");
            ex(1, ch, t, t + 40, 1'b0, "inv_pend");
        end
        to_edge(t + 7);
        wr(0, 4, r);
        wr(0, 6, r);
        to_edge(t + 13);
        wr(3, 9, r);
        to_edge(t + 25);
        wr(0, 0, r);
        to_edge(t + 41);

        // sync restart with a pending divisor on ch1
        do_reset(1'b0);
        wr(0, 3, t);
        wr(1, 5, r);
        to_edge(t + 20);
        wr(1, 4, r);
        ex(1, 1, r, r, 1'b1, "sy_pend");
        pulse_sync(s);
        ex(1, 1, s, s + 10, 1'b0, "sy_pend_clr");
        ex(0, 0, s, s + 2, 1'b0, "sy0_lo");
        ex(0, 0, s + 3, s + 5, 1'b1, "sy0_hi");
        ex(0, 0, s + 6, s + 8, 1'b0, "sy0_lo2");
        ex(0, 0, s + 9, s + 9, 1'b1, "sy0_hi2");
        ex(0, 1, s, s + 3, 1'b0, "sy1_lo");
        ex(0, 1, s + 4, s + 7, 1'b1, "sy1_hi");
        ex(0, 1, s + 8, s + 11, 1'b0, "sy1_lo2");
        ex(0, 1, s + 12, s + 12, 1'b1, "sy1_hi2");
        to_edge(s + 13);

        // timebase spacing, unaffected by sync
        do_reset(1'b0);
        r = cyc;
        for (int c = r + 1; c <= r + 24; c++) begin
            ex(2, 0, c, c, ((c - r) % TD) == 0, "tick");
        end
        to_edge(r + 5);
        pulse_sync(s);
        to_edge(r + 14);
        pulse_sync(s);
        to_edge(r + 25);

        to_edge(last + 2);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL leftover observed=%0d expected=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
